udp_cmd_rx: RTL and testbench
=============================

Name: udp_cmd_rx

Overview:
- Receive-side counterpart of the camera-to-UDP transmit path.
- Parses GMII receive frames from the host PC (preamble/SFD, Ethernet II, IPv4, UDP) and extracts a 2-byte control payload.
- Latches host MAC, host IP and the display/stream mode. These registered outputs feed the pc_mac, pc_ip and mode inputs of the transmit path.
- Sits in the eth_clk domain, directly behind the RGMII-to-GMII receive adapter.

Parameters:
BOARD_MAC, 48'h00_11_22_33_44_55, accepted destination MAC; 48'hFF_FF_FF_FF_FF_FF is always accepted as well.
BOARD_IP, 32'hC0_A8_00_02, accepted destination IP (192.168.0.2).
BOARD_PORT, 16'd1234, accepted UDP destination port.
DEF_PC_MAC, 48'hFF_FF_FF_FF_FF_FF, reset value of pc_mac.
DEF_PC_IP, 32'hC0_A8_00_03, reset value of pc_ip.
MAGIC, 8'h5A, required first payload byte.

Ports:
clk  input  1  GMII receive clock (eth_clk domain).
rst_n  input  1  reset; asynchronous assert, active-low.
gmii_rx_dv  input  1  receive data valid.
gmii_rx_er  input  1  receive error.
gmii_rxd  input  8  receive byte.
pc_mac  output  48  source MAC of the last accepted command.
pc_ip  output  32  source IP of the last accepted command.
mode  output  2  payload byte 1, bits [1:0], of the last accepted command.
cmd_valid  output  1  one-cycle pulse when the outputs update.
drop_cnt  output  8  saturating count of malformed frames.

Behaviour:
- Reset values: pc_mac=DEF_PC_MAC, pc_ip=DEF_PC_IP, mode=2'd0, cmd_valid=0, drop_cnt=0. FSM goes to IDLE and all header/byte counters clear.
- Reset asserted mid-frame: the partial frame is discarded. After release the FSM stays in IDLE until gmii_rx_dv has been sampled low at least once, so the tail of the interrupted frame is never parsed.
- All inputs are sampled on the rising clk edge. The 11-bit byte counter resets on every state change.
- FSM states: IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, WAIT_END, COMMIT.
- IDLE: rx_dv=1 and rxd=8'h55 -> PREAMBLE. rx_dv=1 with any other byte -> WAIT_END, not counted.
- PREAMBLE: 8'h55 stays (any count). 8'hD5 -> ETH_HDR. Any other byte -> WAIT_END, counted.
- ETH_HDR, 14 bytes:
  - Bytes 0-5 are the destination MAC; it must equal BOARD_MAC or broadcast.
  - Bytes 6-11 are the source MAC, captured into a shadow register.
  - Bytes 12-13 are the EtherType; it must be 16'h0800.
- IP_HDR, 20 bytes:
  - Byte 0 must be 8'h45.
  - Byte 9 must be 8'h11.
  - Bytes 12-15 are the source IP, captured into a shadow register.
  - Bytes 16-19 must equal BOARD_IP.
  - IP checksum is not checked.
- UDP_HDR, 8 bytes: bytes 2-3 must equal BOARD_PORT. Other fields are ignored.
- PAYLOAD:
  - Byte 0 must equal MAGIC; a mismatch is a counted drop.
  - Byte 1 bits [1:0] go into the shadow mode register.
  - After byte 1 a "good" flag is set and the FSM goes to WAIT_END.
- Any filter mismatch (MAC, EtherType, protocol, IP, port) -> WAIT_END, NOT counted (frame is not for us).
- WAIT_END: bytes are ignored (extra payload, padding, FCS). On rx_dv=0: if good and no error was flagged -> COMMIT, else -> IDLE. FCS is not checked.
- COMMIT, one cycle:
  - pc_mac, pc_ip and mode are loaded from the shadow registers and cmd_valid=1 in the same cycle.
  - The FSM goes to IDLE.
  - Latency: outputs change on the 2nd rising edge after the first rx_dv=0 sample.
- rx_dv falls in PREAMBLE/ETH_HDR/IP_HDR/UDP_HDR/PAYLOAD (truncation): counted drop, -> IDLE directly.
- rx_er=1 in any state except IDLE: sets the error flag, and the frame becomes a counted drop at its end. The FSM goes to WAIT_END if it is not already there.
- Each frame increments drop_cnt at most once; drop_cnt holds at 8'hFF.
- Shadow registers never affect outputs except in COMMIT. Rejected frames leave pc_mac, pc_ip and mode unchanged.
- Back-to-back frames: a new preamble is accepted on the cycle after COMMIT, or one cycle after rx_dv falls on a rejected frame. This is fine for the minimum 12-byte IFG.

Test Plan:
1. Valid frame: 7x 55, D5, dst BOARD_MAC, src 48'hA0B1C2D3E4F5, type 0800, IP 45…11…src C0A80064 dst C0A80002, UDP dport 04D2, payload 5A 02, then 4 FCS bytes -> 2 cycles after rx_dv falls: pc_mac=A0B1C2D3E4F5, pc_ip=C0A80064, mode=2, cmd_valid high exactly 1 cycle, drop_cnt=0.
2. Same frame with dst MAC broadcast -> accepted. Repeat with dst IP C0A80009 -> no cmd_valid, outputs unchanged, drop_cnt unchanged.
3. Valid frame with rx_er pulsed on payload byte 0 -> no cmd_valid, drop_cnt=1. Same with payload 5B 01 -> drop_cnt=2.
4. rx_dv dropped after IP byte 7, then a valid frame with payload 5A 03 after a 12-cycle gap -> drop_cnt+1, then mode=3 with one cmd_valid.
5. Two valid frames (mode 1, then mode 2) with a 12-cycle IFG -> two cmd_valid pulses, final mode=2. 300 truncated frames -> drop_cnt=8'hFF.
6. rst_n asserted mid UDP header and released while rx_dv is still high -> tail ignored, outputs equal reset values, next valid frame is accepted normally.

Source files
------------

// File: rtl/udp_cmd_rx_if.sv
// GMII receive byte stream as delivered by the RGMII-to-GMII adapter.
interface udp_cmd_rx_if;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] gmii_rxd;

    modport master (output gmii_rx_dv, gmii_rx_er, gmii_rxd);
    modport slave  (input  gmii_rx_dv, gmii_rx_er, gmii_rxd);
endinterface

// File: rtl/udp_cmd_rx.sv
// Parses host Ethernet/IPv4/UDP command frames and latches host MAC, host IP and mode.
// Filter misses are silently ignored; malformed or errored frames bump drop_cnt once.
module udp_cmd_rx #(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = 32'hC0_A8_00_02,
    parameter logic [15:0] BOARD_PORT = 16'd1234,
    parameter logic [47:0] DEF_PC_MAC = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] DEF_PC_IP  = 32'hC0_A8_00_03,
    parameter logic [7:0]  MAGIC      = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    udp_cmd_rx_if.slave rx,
    output logic [47:0] pc_mac,
    output logic [31:0] pc_ip,
    output logic [1:0]  mode,
    output logic        cmd_valid,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, WAIT_END, COMMIT
    } state_t;

    state_t      state;
    logic [10:0] byte_cnt;
    logic        armed, good, err, bad, uni_ok, bc_ok;
    logic [47:0] sh_mac;
    logic [31:0] sh_ip;
    logic [1:0]  sh_mode;
    logic [7:0]  mac_b, ip_b, d;
    logic        dv, er, in_hdr;

    assign dv = rx.gmii_rx_dv;
    assign er = rx.gmii_rx_er;
    assign d  = rx.gmii_rxd;
    assign in_hdr = state inside {PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD};

    always_comb begin
        mac_b = '0;
        ip_b  = '0;
        case (byte_cnt[2:0])
            3'd0:    mac_b = BOARD_MAC[47:40];
            3'd1:    mac_b = BOARD_MAC[39:32];
            3'd2:    mac_b = BOARD_MAC[31:24];
            3'd3:    mac_b = BOARD_MAC[23:16];
            3'd4:    mac_b = BOARD_MAC[15:8];
            3'd5:    mac_b = BOARD_MAC[7:0];
            default: mac_b = '0;
        endcase
        case (byte_cnt[1:0])
            2'd0: ip_b = BOARD_IP[31:24];
            2'd1: ip_b = BOARD_IP[23:16];
            2'd2: ip_b = BOARD_IP[15:8];
            2'd3: ip_b = BOARD_IP[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            armed     <= 1'b0;
            good      <= 1'b0;
            err       <= 1'b0;
            bad       <= 1'b0;
            uni_ok    <= 1'b0;
            bc_ok     <= 1'b0;
            sh_mac    <= '0;
            sh_ip     <= '0;
            sh_mode   <= '0;
            pc_mac    <= DEF_PC_MAC;
            pc_ip     <= DEF_PC_IP;
            mode      <= '0;
            cmd_valid <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            // armed stays low after reset until the line goes idle, so an interrupted frame's tail is skipped
            if (!dv) armed <= 1'b1;
            if (dv && byte_cnt != '1) byte_cnt <= byte_cnt + 11'd1;

            if (in_hdr && !dv) begin
                state    <= IDLE;
                byte_cnt <= '0;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else if (in_hdr && er) begin
                err      <= 1'b1;
                state    <= WAIT_END;
                byte_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        good     <= 1'b0;
                        err      <= 1'b0;
                        bad      <= 1'b0;
                        byte_cnt <= '0;
                        if (armed && dv) state <= (d == 8'h55) ? PREAMBLE : WAIT_END;
                    end
                    PREAMBLE: begin
                        if (d == 8'hD5) begin
                            state    <= ETH_HDR;
                            byte_cnt <= '0;
                            uni_ok   <= 1'b1;
                            bc_ok    <= 1'b1;
                        end else if (d != 8'h55) begin
                            bad      <= 1'b1;
                            state    <= WAIT_END;
                            byte_cnt <= '0;
                        end
                    end
                    ETH_HDR: begin
                        if (byte_cnt < 11'd6) begin
                            uni_ok <= uni_ok && (d == mac_b);
                            bc_ok  <= bc_ok && (d == 8'hFF);
                            if (byte_cnt == 11'd5 && !((uni_ok && d == mac_b) || (bc_ok && d == 8'hFF))) begin
                                state    <= WAIT_END;
                                byte_cnt <= '0;
                            end
                        end else if (byte_cnt < 11'd12) begin
                            sh_mac <= {sh_mac[39:0], d};
                        end else if ((byte_cnt == 11'd12 && d != 8'h08) || (byte_cnt == 11'd13 && d != 8'h00)) begin
                            state    <= WAIT_END;
                            byte_cnt <= '0;
                        end else if (byte_cnt == 11'd13) begin
                            state    <= IP_HDR;
                            byte_cnt <= '0;
                        end
                    end
                    IP_HDR: begin
                        if (byte_cnt >= 11'd12 && byte_cnt < 11'd16) sh_ip <= {sh_ip[23:0], d};
                        if ((byte_cnt == 11'd0 && d != 8'h45) || (byte_cnt == 11'd9 && d != 8'h11) ||
                            (byte_cnt >= 11'd16 && d != ip_b)) begin
                            state    <= WAIT_END;
                            byte_cnt <= '0;
                        end else if (byte_cnt == 11'd19) begin
                            state    <= UDP_HDR;
                            byte_cnt <= '0;
                        end
                    end
                    UDP_HDR: begin
                        if ((byte_cnt == 11'd2 && d != BOARD_PORT[15:8]) || (byte_cnt == 11'd3 && d != BOARD_PORT[7:0])) begin
                            state    <= WAIT_END;
                            byte_cnt <= '0;
                        end else if (byte_cnt == 11'd7) begin
                            state    <= PAYLOAD;
                            byte_cnt <= '0;
                        end
                    end
                    PAYLOAD: begin
                        if (byte_cnt == 11'd0 && d != MAGIC) begin
                            bad      <= 1'b1;
                            state    <= WAIT_END;
                            byte_cnt <= '0;
                        end else if (byte_cnt == 11'd1) begin
                            sh_mode  <= d[1:0];
                            good     <= 1'b1;
                            state    <= WAIT_END;
                            byte_cnt <= '0;
                        end
                    end
                    WAIT_END: begin
                        if (!dv) begin
                            byte_cnt <= '0;
                            if (good && !err) begin
                                state <= COMMIT;
                            end else begin
                                state <= IDLE;
                                if ((err || bad) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                            end
                        end else if (er) begin
                            err <= 1'b1;
                        end
                    end
                    COMMIT: begin
                        pc_mac    <= sh_mac;
                        pc_ip     <= sh_ip;
                        mode      <= sh_mode;
                        cmd_valid <= 1'b1;
                        state     <= IDLE;
                        byte_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Scoreboarded bench for udp_cmd_rx: frames are classified by a field-level reference model.
module tb_udp_cmd_rx;
    localparam logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP   = 32'hC0_A8_00_02;
    localparam logic [15:0] BOARD_PORT = 16'd1234;
    localparam logic [47:0] DEF_PC_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] DEF_PC_IP  = 32'hC0_A8_00_03;
    localparam logic [7:0]  MAGIC      = 8'h5A;
    localparam int K_IGN = 0, K_DROP = 1, K_ACC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] pc_mac;
    logic [31:0] pc_ip;
    logic [1:0]  mode;
    logic        cmd_valid;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    udp_cmd_rx_if rx_if ();

    udp_cmd_rx #(
        .BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP), .BOARD_PORT(BOARD_PORT),
        .DEF_PC_MAC(DEF_PC_MAC), .DEF_PC_IP(DEF_PC_IP), .MAGIC(MAGIC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_if),
        .pc_mac(pc_mac), .pc_ip(pc_ip), .mode(mode),
        .cmd_valid(cmd_valid), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [1:0]  mode;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [7:0]  frm[$];
    logic [7:0]  hold[$];
    int          tests = 0, fails = 0, exp_drop = 0;
    logic [47:0] cur_mac;
    logic [31:0] cur_ip;
    logic [1:0]  cur_mode;
    longint      cyc = 0, fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic put_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    task automatic make_frame(input int npre, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] etype, input logic [7:0] ver, input logic [7:0] proto,
                              input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] dport,
                              input logic [7:0] p0, input logic [7:0] p1);
        frm.delete();
        repeat (npre) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        put_bytes(dst, 6); put_bytes(src, 6); put_bytes(etype, 2);
        put_bytes(ver, 1); put_bytes(8'h00, 1); put_bytes(16'd30, 2); put_bytes($urandom, 4);
        put_bytes(8'h40, 1); put_bytes(proto, 1); put_bytes($urandom, 2); put_bytes(sip, 4); put_bytes(dip, 4);
        put_bytes($urandom, 2); put_bytes(dport, 2); put_bytes(16'd10, 2); put_bytes($urandom, 2);
        frm.push_back(p0); frm.push_back(p1);
        repeat ($urandom_range(0, 3)) put_bytes($urandom, 1);
        put_bytes($urandom, 4);
    endtask

    // Reference classification of the first len bytes of frm.
    function automatic int classify(input int len, input int er_at, output int hdr);
        int          p = 0;
        logic [47:0] dst;
        logic [31:0] bip = BOARD_IP;
        logic [15:0] bport = BOARD_PORT;
        hdr = 0;
        if (er_at >= 1 && er_at < len) return K_DROP;
        while (p < len && frm[p] == 8'h55) p++;
        if (p >= len || frm[p] != 8'hD5) return K_DROP;
        hdr = p + 1;
        for (int k = 0; k < 44; k++) begin
            if (hdr + k >= len) return K_DROP;
            if (k == 5) begin
                dst = {frm[hdr], frm[hdr+1], frm[hdr+2], frm[hdr+3], frm[hdr+4], frm[hdr+5]};
                if (dst != BOARD_MAC && dst != 48'hFFFF_FFFF_FFFF) return K_IGN;
            end
            if (k == 12 && frm[hdr+k] != 8'h08) return K_IGN;
            if (k == 13 && frm[hdr+k] != 8'h00) return K_IGN;
            if (k == 14 && frm[hdr+k] != 8'h45) return K_IGN;
            if (k == 23 && frm[hdr+k] != 8'h11) return K_IGN;
            if (k >= 30 && k <= 33 && frm[hdr+k] != bip[8*(33-k) +: 8]) return K_IGN;
            if (k == 36 && frm[hdr+k] != bport[15:8]) return K_IGN;
            if (k == 37 && frm[hdr+k] != bport[7:0]) return K_IGN;
            if (k == 42 && frm[hdr+k] != MAGIC) return K_DROP;
        end
        return K_ACC;
    endfunction

    task automatic drv(input logic [7:0] b, input logic e);
        @(negedge clk);
        rx_if.gmii_rx_dv = 1'b1;
        rx_if.gmii_rx_er = e;
        rx_if.gmii_rxd   = b;
    endtask

    task automatic idle_and_check(input int gap);
        @(negedge clk);
        rx_if.gmii_rx_dv = 1'b0;
        rx_if.gmii_rx_er = 1'b0;
        rx_if.gmii_rxd   = 8'h00;
        fall_cyc = cyc;
        repeat (gap) @(negedge clk);
        chk("drop_cnt", drop_cnt, exp_drop);
        chk("pc_mac", pc_mac, cur_mac);
        chk("pc_ip", pc_ip, cur_ip);
        chk("mode", mode, cur_mode);
    endtask

    task automatic send(input int len, input int er_at);
        int   hdr, kind;
        cmd_t c;
        kind = classify(len, er_at, hdr);
        if (kind == K_ACC) begin
            c.mac  = {frm[hdr+6], frm[hdr+7], frm[hdr+8], frm[hdr+9], frm[hdr+10], frm[hdr+11]};
            c.ip   = {frm[hdr+26], frm[hdr+27], frm[hdr+28], frm[hdr+29]};
            c.mode = frm[hdr+43][1:0];
            exp_q.push_back(c);
            cur_mac = c.mac; cur_ip = c.ip; cur_mode = c.mode;
        end else if (kind == K_DROP && exp_drop < 255) begin
            exp_drop++;
        end
        for (int i = 0; i < len; i++) drv(frm[i], i == er_at);
        idle_and_check(12);
    endtask

    task automatic send_valid(input logic [47:0] dst, input logic [47:0] src, input logic [31:0] sip,
                              input logic [31:0] dip, input logic [7:0] p0, input logic [7:0] p1);
        make_frame(7, dst, src, 16'h0800, 8'h45, 8'h11, sip, dip, BOARD_PORT, p0, p1);
        send(frm.size(), -1);
    endtask

    // Monitor: every cmd_valid pulse must match the oldest expected command.
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cmd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cmd_valid: actual pulse (mac %0h mode %0d) required none", pc_mac, mode);
                end else begin
                    c = exp_q.pop_front();
                    chk("cmd_mac", pc_mac, c.mac);
                    chk("cmd_ip", pc_ip, c.ip);
                    chk("cmd_mode", mode, c.mode);
                    chk("cmd_latency", cyc - fall_cyc, 2);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int mut, len, er_at, npre;
        logic [47:0] dst;
        logic [15:0] etype, dport;
        logic [7:0]  ver, proto, p0;
        logic [31:0] dip;

        rst_n = 1'b0;
        rx_if.gmii_rx_dv = 1'b0;
        rx_if.gmii_rx_er = 1'b0;
        rx_if.gmii_rxd   = 8'h00;
        cur_mac = DEF_PC_MAC; cur_ip = DEF_PC_IP; cur_mode = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_pc_mac", pc_mac, DEF_PC_MAC);
        chk("rst_pc_ip", pc_ip, DEF_PC_IP);
        chk("rst_mode", mode, 2'd0);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_valid(BOARD_MAC, 48'hA0B1C2D3E4F5, 32'hC0A80064, BOARD_IP, 8'h5A, 8'h02);
        send_valid(48'hFFFF_FFFF_FFFF, 48'hA0B1C2D3E4F6, 32'hC0A80065, BOARD_IP, 8'h5A, 8'h01);
        send_valid(BOARD_MAC, 48'h102030405060, 32'hC0A80066, 32'hC0A80009, 8'h5A, 8'h03);

        make_frame(7, BOARD_MAC, 48'h0102_0304_0506, 16'h0800, 8'h45, 8'h11, 32'hC0A80070, BOARD_IP, BOARD_PORT, 8'h5A, 8'h01);
        send(frm.size(), 8 + 42);
        send_valid(BOARD_MAC, 48'h0102_0304_0507, 32'hC0A80071, BOARD_IP, 8'h5B, 8'h01);

        make_frame(7, BOARD_MAC, 48'h0102_0304_0508, 16'h0800, 8'h45, 8'h11, 32'hC0A80072, BOARD_IP, BOARD_PORT, 8'h5A, 8'h02);
        send(8 + 14 + 8, -1);
        send_valid(BOARD_MAC, 48'hDEAD_BEEF_0001, 32'hC0A80073, BOARD_IP, 8'h5A, 8'h03);

        send_valid(BOARD_MAC, 48'hDEAD_BEEF_0002, 32'hC0A80074, BOARD_IP, 8'h5A, 8'h01);
        send_valid(BOARD_MAC, 48'hDEAD_BEEF_0003, 32'hC0A80075, BOARD_IP, 8'h5A, 8'h02);

        for (int n = 0; n < 300; n++) begin
            make_frame(7, BOARD_MAC, 48'h0, 16'h0800, 8'h45, 8'h11, 32'h0, BOARD_IP, BOARD_PORT, 8'h5A, 8'h01);
            send($urandom_range(1, 30), -1);
        end
        chk("drop_saturated", drop_cnt, 8'hFF);

        // Reset mid UDP header, released while the line is still busy with a complete frame.
        make_frame(7, BOARD_MAC, 48'h0A0B_0C0D_0E0F, 16'h0800, 8'h45, 8'h11, 32'hC0A80080, BOARD_IP, BOARD_PORT, 8'h5A, 8'h01);
        hold = frm;
        make_frame(3, BOARD_MAC, 48'h1122_3344_5566, 16'h0800, 8'h45, 8'h11, 32'hC0A80081, BOARD_IP, BOARD_PORT, 8'h5A, 8'h03);
        for (int i = 0; i < 44; i++) drv(hold[i], 1'b0);
        rst_n = 1'b0;
        for (int i = 44; i < 48; i++) drv(hold[i], 1'b0);
        drv(frm[0], 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i < frm.size(); i++) drv(frm[i], 1'b0);
        exp_drop = 0;
        cur_mac = DEF_PC_MAC; cur_ip = DEF_PC_IP; cur_mode = 2'd0;
        idle_and_check(12);
        send_valid(BOARD_MAC, 48'h7766_5544_3322, 32'hC0A800C8, BOARD_IP, 8'h5A, 8'h02);

        for (int n = 0; n < 150; n++) begin
            npre  = $urandom_range(1, 7);
            dst   = $urandom_range(0, 1) ? BOARD_MAC : 48'hFFFF_FFFF_FFFF;
            etype = 16'h0800; ver = 8'h45; proto = 8'h11; dip = BOARD_IP; dport = BOARD_PORT; p0 = MAGIC;
            mut   = $urandom_range(0, 13);
            case (mut)
                0: dst   = {16'($urandom), $urandom};
                1: etype = 16'h0806;
                2: ver   = 8'h46;
                3: proto = 8'h06;
                4: dip   = $urandom;
                5: dport = 16'($urandom);
                6: p0    = 8'($urandom);
                default: ;
            endcase
            make_frame(npre, dst, {16'($urandom), $urandom}, etype, ver, proto, $urandom, dip, dport, p0, 8'($urandom));
            if (mut == 7) frm[npre] = 8'h54;
            len   = frm.size();
            er_at = -1;
            if (mut == 8) len = $urandom_range(1, frm.size() - 1);
            if (mut == 9) er_at = $urandom_range(1, frm.size() - 1);
            send(len, er_at);
        end

        repeat (20) @(negedge clk);
        chk("pending_cmds", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
